// File: rtl/dht11_responder_pkg.sv
// dht_pkg: DHT11 state codes, 50 MHz timing defaults, frame length and checksum helper.
package dht_pkg;
    typedef logic [2:0] dht_state_t;
    localparam dht_state_t ST_IDLE       = 3'd0;
    localparam dht_state_t ST_HOST_LOW   = 3'd1;
    localparam dht_state_t ST_RESP_DELAY = 3'd2;
    localparam dht_state_t ST_RESP_LOW   = 3'd3;
    localparam dht_state_t ST_RESP_HIGH  = 3'd4;
    localparam dht_state_t ST_BIT_LOW    = 3'd5;
    localparam dht_state_t ST_BIT_HIGH   = 3'd6;
    localparam dht_state_t ST_END_LOW    = 3'd7;

    localparam int unsigned DHT_T_START_MIN  = 500000;
    localparam int unsigned DHT_T_RESP_DELAY = 1500;
    localparam int unsigned DHT_T_RESP_LOW   = 4000;
    localparam int unsigned DHT_T_RESP_HIGH  = 4000;
    localparam int unsigned DHT_T_BIT_LOW    = 2500;
    localparam int unsigned DHT_T_BIT0_HIGH  = 1300;
    localparam int unsigned DHT_T_BIT1_HIGH  = 3500;
    localparam int unsigned DHT_T_END_LOW    = 2500;

    localparam int unsigned FRAME_BITS = 40;

    function automatic logic [7:0] dht_cksum(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
        return a + b + c + d;
    endfunction
endpackage

// File: rtl/dht11_responder_line_sync.sv
// dht_line_sync: 2-flop synchronizer for the DHT11 line with registered rise/fall detect.
module dht_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;

    // Reset to low so a line already held low after reset never looks like a fresh fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            o_rise <= r_meta & ~r_sync;
            o_fall <= ~r_meta & r_sync;
        end
    end

    assign o_level = r_sync;
endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: open-drain DHT11 sensor emulator replying to a host start pulse with a 40-bit frame.
// Define DHT11_CKSUM_FAULT_EN to add cksum_fault, which flips the transmitted checksum LSB.
module dht11_responder
    import dht_pkg::*;
#(
    parameter int unsigned T_START_MIN  = DHT_T_START_MIN,
    parameter int unsigned T_RESP_DELAY = DHT_T_RESP_DELAY,
    parameter int unsigned T_RESP_LOW   = DHT_T_RESP_LOW,
    parameter int unsigned T_RESP_HIGH  = DHT_T_RESP_HIGH,
    parameter int unsigned T_BIT_LOW    = DHT_T_BIT_LOW,
    parameter int unsigned T_BIT0_HIGH  = DHT_T_BIT0_HIGH,
    parameter int unsigned T_BIT1_HIGH  = DHT_T_BIT1_HIGH,
    parameter int unsigned T_END_LOW    = DHT_T_END_LOW
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        dht11,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_CKSUM_FAULT_EN
    input  logic       cksum_fault,
`endif
    output logic       busy,
    output logic       frame_done
);
    localparam logic [19:0] L_START      = 20'(T_START_MIN);
    localparam logic [19:0] L_RESP_DELAY = 20'(T_RESP_DELAY - 1);
    localparam logic [19:0] L_RESP_LOW   = 20'(T_RESP_LOW - 1);
    localparam logic [19:0] L_RESP_HIGH  = 20'(T_RESP_HIGH - 1);
    localparam logic [19:0] L_BIT_LOW    = 20'(T_BIT_LOW - 1);
    localparam logic [19:0] L_BIT0_HIGH  = 20'(T_BIT0_HIGH - 1);
    localparam logic [19:0] L_BIT1_HIGH  = 20'(T_BIT1_HIGH - 1);
    localparam logic [19:0] L_END_LOW    = 20'(T_END_LOW - 1);
    localparam logic [5:0]  L_LAST_BIT   = 6'(FRAME_BITS - 1);

    dht_state_t            r_state;
    logic [19:0]           r_cnt;
    logic [5:0]            r_bit;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_frame_done;
    logic                  w_level;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_drive_low;
    logic                  w_start_ok;
    logic [19:0]           w_dur_m1;
    dht_state_t            w_next;
    logic [7:0]            w_cksum;

    dht_line_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_line (dht11),
        .o_level(w_level),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

`ifdef DHT11_CKSUM_FAULT_EN
    assign w_cksum = dht_cksum(hum_int, hum_dec, temp_int, temp_dec) ^ {7'd0, cksum_fault};
`else
    assign w_cksum = dht_cksum(hum_int, hum_dec, temp_int, temp_dec);
`endif

    assign w_start_ok = r_cnt >= L_START;
    assign w_dur_m1 = (r_state == ST_RESP_DELAY) ? L_RESP_DELAY :
                      (r_state == ST_RESP_LOW)   ? L_RESP_LOW   :
                      (r_state == ST_RESP_HIGH)  ? L_RESP_HIGH  :
                      (r_state == ST_BIT_LOW)    ? L_BIT_LOW    :
                      (r_state == ST_BIT_HIGH)   ? (r_shift[FRAME_BITS-1] ? L_BIT1_HIGH : L_BIT0_HIGH) :
                                                   L_END_LOW;
    assign w_next = (r_state == ST_RESP_DELAY) ? ST_RESP_LOW  :
                    (r_state == ST_RESP_LOW)   ? ST_RESP_HIGH :
                    (r_state == ST_RESP_HIGH)  ? ST_BIT_LOW   :
                    (r_state == ST_BIT_LOW)    ? ST_BIT_HIGH  :
                    (r_state == ST_BIT_HIGH)   ? ((r_bit == L_LAST_BIT) ? ST_END_LOW : ST_BIT_LOW) :
                                                 ST_IDLE;

    // Drive is decoded from state so the async reset releases the line immediately.
    assign w_drive_low = (r_state == ST_RESP_LOW) || (r_state == ST_BIT_LOW) || (r_state == ST_END_LOW);
    assign dht11       = w_drive_low ? 1'b0 : 1'bz;
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_HOST_LOW);
    assign frame_done  = r_frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_state <= ST_HOST_LOW;
                    end
                end
                ST_HOST_LOW: begin
                    if (w_rise) begin
                        r_cnt   <= '0;
                        r_state <= w_start_ok ? ST_RESP_DELAY : ST_IDLE;
                        if (w_start_ok) begin
                            r_shift <= {hum_int, hum_dec, temp_int, temp_dec, w_cksum};
                            r_bit   <= '0;
                        end
                    end else if (!w_level && !w_start_ok) begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
                // Every reply phase is a fixed-length timer; the line input is ignored here.
                default: begin
                    if (r_cnt == w_dur_m1) begin
                        r_cnt        <= '0;
                        r_state      <= w_next;
                        r_frame_done <= (r_state == ST_END_LOW);
                        if (r_state == ST_BIT_HIGH) begin
                            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                            r_bit   <= r_bit + 6'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: directed and random frames measured on the open-drain line against a frame model.
`timescale 1ns/1ps
module tb_dht11_responder;
    localparam int TSM = 400;
    localparam int TRD = 15;
    localparam int TRL = 40;
    localparam int TRH = 40;
    localparam int TBL = 25;
    localparam int TB0 = 13;
    localparam int TB1 = 35;
    localparam int TEL = 25;
    localparam int LIMIT = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_low = 1'b0;
    logic [7:0] hi = 8'h00;
    logic [7:0] hd = 8'h00;
    logic [7:0] ti = 8'h00;
    logic [7:0] td = 8'h00;
    logic       busy;
    logic       frame_done;
    wire        dht11;
    int         checks = 0;
    int         failures = 0;
    int         fd_cnt = 0;
    int         dut_low = 0;
    int         busy_bad = 0;
`ifdef DHT11_CKSUM_FAULT_EN
    logic       cksum_fault = 1'b0;
`endif

    pullup (dht11);
    assign dht11 = host_low ? 1'b0 : 1'bz;
    always #5 clk = ~clk;

    dht11_responder #(
        .T_START_MIN (TSM), .T_RESP_DELAY(TRD), .T_RESP_LOW(TRL), .T_RESP_HIGH(TRH),
        .T_BIT_LOW   (TBL), .T_BIT0_HIGH (TB0), .T_BIT1_HIGH(TB1), .T_END_LOW (TEL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dht11      (dht11),
        .hum_int    (hi),
        .hum_dec    (hd),
        .temp_int   (ti),
        .temp_dec   (td),
`ifdef DHT11_CKSUM_FAULT_EN
        .cksum_fault(cksum_fault),
`endif
        .busy       (busy),
        .frame_done (frame_done)
    );

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        if (!host_low && dht11 === 1'b0) dut_low <= dut_low + 1;
    end

    function automatic logic [39:0] model(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d, input bit f);
        int unsigned s;
        s = (a + b + c + d) % 256;
        if (f) s = s ^ 1;
        return {a[7:0], b[7:0], c[7:0], d[7:0], s[7:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        hi = a; hd = b; ti = c; td = d;
    endtask

    // Counts negedge samples for which the line stays at lvl, bounded by LIMIT.
    task automatic hold_time(input logic lvl, input bit chkb, output int n);
        n = 0;
        while (dht11 === lvl && n < LIMIT) begin
            if (chkb && busy !== 1'b1) busy_bad++;
            @(negedge clk);
            n++;
        end
    endtask

    // mode 1: zero the input bytes at bit mbit; mode 2: assert reset during BIT_LOW of bit mbit.
    task automatic run_frame(input string tag, input logic [39:0] exp, input int host_len,
                             input int mode, input int mbit);
        int n;
        int fd0;
        logic [39:0] got;
        got = '0;
        busy_bad = 0;
        host_low = 1'b1;
        repeat (host_len) @(negedge clk);
        host_low = 1'b0;
        fd0 = fd_cnt;
        #1;
        hold_time(1'b1, 1'b0, n);
        check({tag, ":resp_delay"}, 64'(n >= TRD && n <= TRD + 5), 64'd1);
        check({tag, ":busy_qual"}, 64'(busy), 64'd1);
        hold_time(1'b0, 1'b1, n);
        check({tag, ":resp_low"}, 64'(n), 64'(TRL));
        hold_time(1'b1, 1'b1, n);
        check({tag, ":resp_high"}, 64'(n), 64'(TRH));
        for (int b = 0; b < 40; b++) begin
            if (b == mbit && mode == 1) set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
            if (b == mbit && mode == 2) begin
                #3 rst = 1'b1;
                #1;
                check({tag, ":rst_line"}, 64'(dht11), 64'd1);
                check({tag, ":rst_busy"}, 64'(busy), 64'd0);
                host_low = 1'b1;
                return;
            end
            hold_time(1'b0, 1'b1, n);
            check($sformatf("%s:bit%0d_low", tag, b), 64'(n), 64'(TBL));
            hold_time(1'b1, 1'b1, n);
            check($sformatf("%s:bit%0d_high", tag, b), 64'(n), 64'(exp[39-b] ? TB1 : TB0));
            got[39-b] = (n > (TB0 + TB1) / 2);
        end
        hold_time(1'b0, 1'b1, n);
        check({tag, ":end_low"}, 64'(n), 64'(TEL));
        check({tag, ":done_pulse"}, 64'(frame_done), 64'd1);
        check({tag, ":busy_end"}, 64'(busy), 64'd0);
        check({tag, ":frame"}, 64'(got), 64'(exp));
        repeat (3) @(negedge clk);
        check({tag, ":done_count"}, 64'(fd_cnt - fd0), 64'd1);
        check({tag, ":busy_held"}, 64'(busy_bad), 64'd0);
    endtask

    task automatic expect_silence(input string tag, input int host_len);
        int d0;
        int f0;
        if (host_len > 0) begin
            host_low = 1'b1;
            repeat (host_len) @(negedge clk);
        end
        host_low = 1'b0;
        d0 = dut_low;
        f0 = fd_cnt;
        repeat (TSM + 200) @(negedge clk);
        check({tag, ":no_drive"}, 64'(dut_low - d0), 64'd0);
        check({tag, ":no_busy"}, 64'(busy), 64'd0);
        check({tag, ":no_done"}, 64'(fd_cnt - f0), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [39:0] e;
        repeat (5) @(negedge clk);
        check("reset:line", 64'(dht11), 64'd1);
        check("reset:busy", 64'(busy), 64'd0);
        check("reset:done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        e = model(32'h37, 0, 32'h19, 0, 1'b0);
        check("model:basic", 64'(e[7:0]), 64'h50);
        run_frame("basic", e, 720, 0, 0);
        repeat (20) @(negedge clk);

        expect_silence("short", 80);
        expect_silence("below_min", TSM - 50);

        set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_frame("wrap", model(255, 255, 255, 255, 1'b0), 720, 0, 0);
        repeat (20) @(negedge clk);

        r = $urandom;
        set_bytes(r[31:24], r[23:16], r[15:8], r[7:0]);
        run_frame("latched", model(r[31:24], r[23:16], r[15:8], r[7:0], 1'b0), 720, 1, 5);
        repeat (20) @(negedge clk);

        r = $urandom;
        set_bytes(r[31:24], r[23:16], r[15:8], r[7:0]);
        run_frame("above_min", model(r[31:24], r[23:16], r[15:8], r[7:0], 1'b0), TSM + 50, 0, 0);
        repeat (20) @(negedge clk);

        r = $urandom;
        set_bytes(r[31:24], r[23:16], r[15:8], r[7:0]);
        run_frame("midrst", model(r[31:24], r[23:16], r[15:8], r[7:0], 1'b0), 720, 2, 12);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        repeat (3 * TSM) @(negedge clk);
        expect_silence("held_low", 0);

        r = $urandom;
        set_bytes(r[31:24], r[23:16], r[15:8], r[7:0]);
        run_frame("after_rst", model(r[31:24], r[23:16], r[15:8], r[7:0], 1'b0), 720, 0, 0);
        repeat (20) @(negedge clk);

`ifdef DHT11_CKSUM_FAULT_EN
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        cksum_fault = 1'b1;
        run_frame("fault_on", model(32'h37, 0, 32'h19, 0, 1'b1), 720, 0, 0);
        repeat (20) @(negedge clk);
        cksum_fault = 1'b0;
        run_frame("fault_off", model(32'h37, 0, 32'h19, 0, 1'b0), 720, 0, 0);
        repeat (20) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
